gmii_tx_framer: RTL and testbench

Transmit-side framer for one switch port. Drains the port's TX FIFO, which the forwarder fills with 9-bit words (bit 8 = in-frame byte, bit 8 = 0 = end-of-frame delimiter). It emits each frame on a GMII transmit interface with preamble, SFD, zero padding to minimum length, CRC-32 FCS and inter-frame gap. One instance sits between each `portNtx` FIFO and its PHY.

---
 rtl/tx_framer_pkg.sv | 36 +++
 rtl/crc32_d8.sv | 22 ++
 rtl/gmii_tx_framer.sv | 199 +++++++++++++++++++
 tb/tb_gmii_tx_framer.sv | 319 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tx_framer_pkg.sv
// Shared types and constants for the GMII transmit framer: FSM states,
// preamble/SFD bytes and the CRC-32 parameters.
package tx_framer_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PRE,
    ST_SFD,
    ST_DATA,
    ST_PAD,
    ST_FCS,
    ST_IFG,
    ST_DRAIN
  } state_t;

  localparam logic [7:0] PREAMBLE_BYTE = 8'h55;
  localparam logic [7:0] SFD_BYTE      = 8'hD5;
  localparam int         PRE_BYTES     = 7;
  localparam int         FCS_BYTES     = 4;

  localparam logic [31:0] CRC_POLY = 32'h04C11DB7;
  localparam logic [31:0] CRC_INIT = 32'hFFFFFFFF;

  function automatic logic [31:0] reflect32(input logic [31:0] v);
    logic [31:0] r;
    r = '0;
    for (int i = 0; i < 32; i++) begin
      r[i] = v[31-i];
    end
    return r;
  endfunction

  // Ethernet shifts data LSB first, so the register works on the bit-reversed polynomial.
  localparam logic [31:0] CRC_POLY_REFL = reflect32(CRC_POLY);

endpackage

// File: rtl/crc32_d8.sv
// Byte-wide next-state function of the reflected IEEE 802.3 CRC-32.
// Purely combinational; the caller owns the CRC register.
module crc32_d8
  import tx_framer_pkg::*;
(
  input  logic [31:0] crc_in,
  input  logic [7:0]  d,
  output logic [31:0] crc_out
);

  always_comb begin
    crc_out = crc_in;
    for (int i = 0; i < 8; i++) begin
      if (crc_out[0] ^ d[i]) begin
        crc_out = (crc_out >> 1) ^ CRC_POLY_REFL;
      end else begin
        crc_out = crc_out >> 1;
      end
    end
  end

endmodule

// File: rtl/gmii_tx_framer.sv
// GMII transmit framer: drains a first-word-fall-through TX FIFO and sends each
// frame with preamble, SFD, zero padding, CRC-32 FCS and inter-frame gap.
module gmii_tx_framer
  import tx_framer_pkg::*;
#(
  parameter int IFG_CYCLES = 12,
  parameter int MIN_LEN    = 60,
  parameter int MAX_LEN    = 1514
) (
  input  logic        sys_clk,
  input  logic        sys_rst_n,
  input  logic [8:0]  tx_dout,
  input  logic        tx_empty,
  output logic        tx_rd_en,
  output logic [7:0]  gmii_txd,
  output logic        gmii_tx_en,
  output logic        gmii_tx_er,
  output logic        busy,
  output logic [15:0] frame_cnt,
  output logic [15:0] abort_cnt
);

  state_t      state, state_nxt;
  logic [10:0] len, len_nxt;
  logic [31:0] crc, crc_nxt;
  logic [15:0] cnt, cnt_nxt;
  logic [7:0]  txd_nxt;
  logic        en_nxt;
  logic        er_nxt;
  logic        frame_inc;
  logic        abort_inc;

  logic [7:0]  crc_d;
  logic [31:0] crc_upd;
  logic [31:0] fcs;

  // Pad bytes feed zeros into the CRC; only real frame bytes come from the FIFO.
  assign crc_d = (state == ST_DATA && tx_dout[8]) ? tx_dout[7:0] : 8'h00;
  assign fcs   = ~crc;
  assign busy  = (state != ST_IDLE);

  crc32_d8 u_crc32_d8 (
    .crc_in  (crc),
    .d       (crc_d),
    .crc_out (crc_upd)
  );

  always_comb begin
    // NOTE: every variable gets a default before the case so no path leaves it
    // unassigned; that is what keeps this block free of inferred latches.
    state_nxt = state;
    len_nxt   = len;
    crc_nxt   = crc;
    cnt_nxt   = cnt;
    txd_nxt   = 8'h00;
    en_nxt    = 1'b0;
    er_nxt    = 1'b0;
    tx_rd_en  = 1'b0;
    frame_inc = 1'b0;
    abort_inc = 1'b0;

    case (state)
      ST_IDLE: begin
        len_nxt = '0;
        crc_nxt = CRC_INIT;
        cnt_nxt = '0;
        if (!tx_empty) begin
          if (tx_dout[8]) begin
            txd_nxt   = PREAMBLE_BYTE;
            en_nxt    = 1'b1;
            state_nxt = ST_PRE;
          end else begin
            tx_rd_en = 1'b1;
          end
        end
      end

      ST_PRE: begin
        txd_nxt = PREAMBLE_BYTE;
        en_nxt  = 1'b1;
        if (cnt == 16'(PRE_BYTES - 2)) begin
          cnt_nxt   = '0;
          state_nxt = ST_SFD;
        end else begin
          cnt_nxt = cnt + 16'd1;
        end
      end

      ST_SFD: begin
        txd_nxt   = SFD_BYTE;
        en_nxt    = 1'b1;
        state_nxt = ST_DATA;
      end

      ST_DATA: begin
        en_nxt = 1'b1;
        // An oversize word stays in the FIFO; DRAIN discards it with the rest.
        if (tx_empty || (len == 11'(MAX_LEN) && tx_dout[8])) begin
          er_nxt    = 1'b1;
          abort_inc = 1'b1;
          state_nxt = ST_DRAIN;
        end else begin
          tx_rd_en = 1'b1;
          if (tx_dout[8]) begin
            txd_nxt = tx_dout[7:0];
            crc_nxt = crc_upd;
            len_nxt = len + 11'd1;
          end else if (len < 11'(MIN_LEN)) begin
            crc_nxt   = crc_upd;
            len_nxt   = len + 11'd1;
            state_nxt = ST_PAD;
          end else begin
            txd_nxt   = fcs[7:0];
            cnt_nxt   = 16'd1;
            state_nxt = ST_FCS;
          end
        end
      end

      ST_PAD: begin
        en_nxt = 1'b1;
        if (len < 11'(MIN_LEN)) begin
          crc_nxt = crc_upd;
          len_nxt = len + 11'd1;
        end else begin
          txd_nxt   = fcs[7:0];
          cnt_nxt   = 16'd1;
          state_nxt = ST_FCS;
        end
      end

      ST_FCS: begin
        en_nxt  = 1'b1;
        txd_nxt = fcs[{cnt[1:0], 3'b000} +: 8];
        if (cnt == 16'(FCS_BYTES - 1)) begin
          frame_inc = 1'b1;
          cnt_nxt   = '0;
          state_nxt = ST_IFG;
        end else begin
          cnt_nxt = cnt + 16'd1;
        end
      end

      ST_IFG: begin
        if (cnt == 16'(IFG_CYCLES - 1)) begin
          cnt_nxt   = '0;
          state_nxt = ST_IDLE;
        end else begin
          cnt_nxt = cnt + 16'd1;
        end
      end

      ST_DRAIN: begin
        if (!tx_empty) begin
          tx_rd_en = 1'b1;
          if (!tx_dout[8]) begin
            cnt_nxt   = '0;
            state_nxt = ST_IFG;
          end
        end
      end

      default: begin
        state_nxt = ST_IDLE;
      end
    endcase

    if (!sys_rst_n) begin
      tx_rd_en = 1'b0;
    end
  end

  always_ff @(posedge sys_clk) begin
    // NOTE: non-blocking assignments here so every register samples the
    // pre-edge values, independent of statement order.
    if (!sys_rst_n) begin
      state      <= ST_IDLE;
      len        <= '0;
      crc        <= CRC_INIT;
      cnt        <= '0;
      gmii_txd   <= 8'h00;
      gmii_tx_en <= 1'b0;
      gmii_tx_er <= 1'b0;
      frame_cnt  <= '0;
      abort_cnt  <= '0;
    end else begin
      state      <= state_nxt;
      len        <= len_nxt;
      crc        <= crc_nxt;
      cnt        <= cnt_nxt;
      gmii_txd   <= txd_nxt;
      gmii_tx_en <= en_nxt;
      gmii_tx_er <= er_nxt;
      frame_cnt  <= frame_cnt + 16'(frame_inc);
      abort_cnt  <= abort_cnt + 16'(abort_inc);
    end
  end

endmodule

// File: tb/tb_gmii_tx_framer.sv
// Directed self-checking bench for gmii_tx_framer: a FIFO model feeds frames,
// a monitor records every tx_en burst, and each burst is compared to a reference.
module tb_gmii_tx_framer;

  logic        sys_clk = 1'b0;
  logic        sys_rst_n = 1'b0;
  logic [8:0]  tx_dout;
  logic        tx_empty;
  logic        tx_rd_en;
  logic [7:0]  gmii_txd;
  logic        gmii_tx_en;
  logic        gmii_tx_er;
  logic        busy;
  logic [15:0] frame_cnt;
  logic [15:0] abort_cnt;

  always #4 sys_clk = ~sys_clk;

  gmii_tx_framer #(
    .IFG_CYCLES (12),
    .MIN_LEN    (60),
    .MAX_LEN    (1514)
  ) dut (
    .sys_clk    (sys_clk),
    .sys_rst_n  (sys_rst_n),
    .tx_dout    (tx_dout),
    .tx_empty   (tx_empty),
    .tx_rd_en   (tx_rd_en),
    .gmii_txd   (gmii_txd),
    .gmii_tx_en (gmii_tx_en),
    .gmii_tx_er (gmii_tx_er),
    .busy       (busy),
    .frame_cnt  (frame_cnt),
    .abort_cnt  (abort_cnt)
  );

  // Standalone CRC unit for the check-value test.
  logic [31:0] u_crc_in;
  logic [7:0]  u_crc_d;
  logic [31:0] u_crc_out;

  crc32_d8 u_crc (
    .crc_in  (u_crc_in),
    .d       (u_crc_d),
    .crc_out (u_crc_out)
  );

  // FIFO model: first-word-fall-through, flushed by reset.
  logic [8:0] mem [0:8191];
  int wr_ptr = 0;
  int rd_ptr = 0;

  assign tx_empty = (rd_ptr == wr_ptr);
  assign tx_dout  = mem[rd_ptr[12:0]];

  always @(posedge sys_clk) begin
    if (!sys_rst_n) rd_ptr <= wr_ptr;
    else if (tx_rd_en && rd_ptr != wr_ptr) rd_ptr <= rd_ptr + 1;
  end

  // Monitor: one entry per tx_en cycle, one length per burst.
  logic [8:0] cap[$];
  int lens[$];
  int starts[$];
  int cyc = 0;
  int en_cycles = 0;
  int seg_len = 0;
  int bad_er = 0;
  logic prev_en = 1'b0;

  always @(negedge sys_clk) begin
    cyc++;
    if (gmii_tx_er && !gmii_tx_en) bad_er++;
    if (gmii_tx_en) begin
      cap.push_back({gmii_tx_er, gmii_txd});
      en_cycles++;
      if (!prev_en) starts.push_back(cyc);
      seg_len++;
    end else if (prev_en) begin
      lens.push_back(seg_len);
      seg_len = 0;
    end
    prev_en = gmii_tx_en;
  end

  int n_checks = 0;
  int n_fail = 0;
  int cap_rd = 0;
  int frame_idx = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(negedge sys_clk);
      #1;
    end
  endtask

  function automatic logic [7:0] gen(input int i, input int seed);
    return 8'((i * 13 + seed) & 255);
  endfunction

  function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] b);
    logic [31:0] r;
    r = c ^ {24'h0, b};
    for (int i = 0; i < 8; i++) r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
    return r;
  endfunction

  task automatic push(input logic [8:0] w);
    mem[wr_ptr[12:0]] = w;
    wr_ptr++;
  endtask

  task automatic push_frame(input int n, input int seed, input bit delim);
    for (int i = 0; i < n; i++) push({1'b1, gen(i, seed)});
    if (delim) push(9'h000);
  endtask

  task automatic wait_seg(input string tag);
    int t;
    t = 0;
    while (lens.size() <= frame_idx && t < 5000) begin
      tick(1);
      t++;
    end
    check({tag, "_seen"}, 32'(lens.size() > frame_idx), 32'd1);
  endtask

  task automatic skip_seg(input string tag);
    wait_seg(tag);
    cap_rd += lens[frame_idx];
    frame_idx++;
  endtask

  task automatic wait_idle(input string tag);
    int t;
    t = 0;
    while (busy && t < 5000) begin
      tick(1);
      t++;
    end
    check({tag, "_idle"}, 32'(busy), 32'd0);
  endtask

  // Reference: preamble, SFD, payload, zero pad to 60, FCS = ~crc LSB first.
  task automatic expect_frame(input string tag, input int n, input int seed);
    logic [8:0]  ex[$];
    logic [31:0] c;
    logic [7:0]  b;
    int total;
    int got_len;
    c = 32'hFFFFFFFF;
    total = (n < 60) ? 60 : n;
    for (int k = 0; k < 7; k++) ex.push_back(9'h055);
    ex.push_back(9'h0D5);
    for (int k = 0; k < total; k++) begin
      b = (k < n) ? gen(k, seed) : 8'h00;
      c = crc_byte(c, b);
      ex.push_back({1'b0, b});
    end
    c = ~c;
    for (int k = 0; k < 4; k++) ex.push_back({1'b0, c[8*k +: 8]});
    wait_seg(tag);
    got_len = lens[frame_idx];
    check({tag, "_len"}, 32'(got_len), 32'(ex.size()));
    for (int k = 0; k < ex.size() && k < got_len; k++)
      check($sformatf("%s[%0d]", tag, k), 32'(cap[cap_rd + k]), 32'(ex[k]));
    cap_rd += got_len;
    frame_idx++;
  endtask

  initial begin
    automatic string s = "123456789";
    logic [31:0] c;
    int base;
    int idx0;
    int e0;
    int t;

    // Reset state, and tx_rd_en held low even with a stray delimiter waiting.
    tick(2);
    check("rst_txd", 32'(gmii_txd), 32'd0);
    check("rst_en", 32'(gmii_tx_en), 32'd0);
    check("rst_er", 32'(gmii_tx_er), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_frame_cnt", 32'(frame_cnt), 32'd0);
    check("rst_abort_cnt", 32'(abort_cnt), 32'd0);
    push(9'h000);
    check("rst_rd_en", 32'(tx_rd_en), 32'd0);
    tick(2);
    sys_rst_n = 1'b1;
    tick(2);

    // CRC unit check value.
    c = 32'hFFFFFFFF;
    for (int i = 0; i < 9; i++) begin
      u_crc_in = c;
      u_crc_d  = s[i];
      #1;
      c = u_crc_out;
    end
    check("crc_check_value", ~c, 32'hCBF43926);

    // Two preloaded 64-byte frames, back to back.
    push_frame(64, 3, 1'b1);
    push_frame(64, 91, 1'b1);
    idx0 = frame_idx;
    expect_frame("f64a", 64, 3);
    check("f64a_frame_cnt", 32'(frame_cnt), 32'd1);
    expect_frame("f64b", 64, 91);
    check("b2b_spacing", 32'(starts[idx0 + 1] - starts[idx0]), 32'd88);
    check("f64b_frame_cnt", 32'(frame_cnt), 32'd2);
    wait_idle("f64");

    // Short frame padded to 60 bytes.
    push_frame(20, 200, 1'b1);
    expect_frame("f20", 20, 200);
    check("f20_frame_cnt", 32'(frame_cnt), 32'd3);
    wait_idle("f20");

    // Underrun after 30 bytes.
    push_frame(30, 17, 1'b0);
    wait_seg("underrun");
    base = cap_rd;
    check("underrun_len", 32'(lens[frame_idx]), 32'd39);
    check("underrun_last_byte", 32'(cap[base + 37]), 32'({1'b0, gen(29, 17)}));
    check("underrun_er_word", 32'(cap[base + 38]), 32'h100);
    skip_seg("underrun");
    check("underrun_abort_cnt", 32'(abort_cnt), 32'd1);
    check("underrun_frame_cnt", 32'(frame_cnt), 32'd3);
    e0 = en_cycles;
    tick(5);
    check("drain_busy", 32'(busy), 32'd1);
    push_frame(5, 40, 1'b1);
    tick(17);
    check("drain_ifg_busy", 32'(busy), 32'd1);
    tick(1);
    check("drain_ifg_done", 32'(busy), 32'd0);
    check("drain_fifo_empty", 32'(tx_empty), 32'd1);
    check("drain_no_tx_en", 32'(en_cycles - e0), 32'd0);

    // Oversize frame followed by a minimum-length frame.
    push_frame(1600, 5, 1'b1);
    push_frame(60, 77, 1'b1);
    wait_seg("oversize");
    base = cap_rd;
    check("oversize_len", 32'(lens[frame_idx]), 32'd1523);
    check("oversize_last_byte", 32'(cap[base + 1521]), 32'({1'b0, gen(1513, 5)}));
    check("oversize_er_word", 32'(cap[base + 1522]), 32'h100);
    skip_seg("oversize");
    check("oversize_abort_cnt", 32'(abort_cnt), 32'd2);
    expect_frame("f60", 60, 77);
    check("f60_frame_cnt", 32'(frame_cnt), 32'd4);
    wait_idle("f60");

    // Stray delimiter while idle.
    e0 = en_cycles;
    push(9'h0AB);
    tick(3);
    check("stray_popped", 32'(tx_empty), 32'd1);
    check("stray_no_tx_en", 32'(en_cycles - e0), 32'd0);
    check("stray_busy", 32'(busy), 32'd0);

    // Reset in the middle of DATA.
    e0 = en_cycles;
    push_frame(40, 9, 1'b1);
    t = 0;
    while (en_cycles < e0 + 20 && t < 200) begin
      tick(1);
      t++;
    end
    check("midrst_reached_data", 32'(en_cycles >= e0 + 20), 32'd1);
    sys_rst_n = 1'b0;
    tick(1);
    check("midrst_txd", 32'(gmii_txd), 32'd0);
    check("midrst_en", 32'(gmii_tx_en), 32'd0);
    check("midrst_er", 32'(gmii_tx_er), 32'd0);
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_rd_en", 32'(tx_rd_en), 32'd0);
    tick(2);
    sys_rst_n = 1'b1;
    check("midrst_frame_cnt", 32'(frame_cnt), 32'd0);
    check("midrst_abort_cnt", 32'(abort_cnt), 32'd0);
    skip_seg("midrst");
    e0 = en_cycles;
    tick(20);
    check("midrst_no_fcs", 32'(en_cycles - e0), 32'd0);

    // frame_cnt wrap from a forced preload.
    force dut.frame_cnt = 16'hFFFF;
    tick(1);
    release dut.frame_cnt;
    tick(1);
    check("wrap_preload", 32'(frame_cnt), 32'hFFFF);
    push_frame(60, 33, 1'b1);
    expect_frame("fwrap", 60, 33);
    check("wrap_frame_cnt", 32'(frame_cnt), 32'd0);

    check("er_without_en", 32'(bad_er), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
